stim_resp_driver: RTL and testbench
===================================

// Module: stim_resp_driver
// PURPOSE
//  Drives the opposite end of a generated combinational datapath block: the
//  upstream side supplies stimulus words, this block drives them onto the
//  DUT's input_data bus and waits a fixed settle time. It then samples the
//  DUT's output_data and returns {stimulus, response} downstream.
//  It also folds every vector into a MISR signature for quick regression compare.
// PARAMETERS
//  IN_W          12       width of stimulus / DUT input_data
//  OUT_W         3        width of DUT output_data
//  SETTLE_CYCLES 2        cycles stimulus is held before response sampled (>=1)
//  SIG_W         16       signature width (>= IN_W+OUT_W)
//  SIG_SEED      16'hFFFF signature value after reset / clear
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst        in   1           synchronous reset, active-high
//  s_valid    in   1           stimulus valid
//  s_ready    out  1           stimulus accept
//  s_data     in   IN_W        stimulus word
//  drv_data   out  IN_W        to DUT input_data
//  dut_resp   in   OUT_W       from DUT output_data
//  m_valid    out  1           result valid
//  m_ready    in   1           result accept
//  m_data     out  IN_W+OUT_W  {stimulus, response}
//  sig_clr    in   1           clear signature and vec_count
//  signature  out  SIG_W       running MISR
//  vec_count  out  16          completed vectors, saturating
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, drv_data=0, m_valid=0, m_data=0, signature=SIG_SEED,
//   vec_count=0, settle counter=0. Reset mid-operation drops the in-flight
//   vector: no m_valid, no signature/count update.
//  FSM IDLE -> SETTLE -> RESP:
//   IDLE: s_ready=1. On s_valid&s_ready: drv_data<=s_data, cnt<=0, ->SETTLE.
//   SETTLE: s_ready=0. cnt increments each cycle. When cnt==SETTLE_CYCLES-1:
//    m_data<={drv_data,dut_resp}, m_valid<=1, update signature and vec_count,
//    ->RESP. m_valid therefore rises SETTLE_CYCLES edges after the accept edge.
//   RESP: m_valid=1. m_data is stable until m_ready. s_ready = m_ready.
//    m_ready & s_valid: result retires and new stimulus loads in the same
//     edge, ->SETTLE (throughput 1 vector per SETTLE_CYCLES+1 cycles).
//    m_ready & !s_valid: m_valid<=0, ->IDLE.
//  drv_data holds the last accepted stimulus until the next accept, and is
//   never changed in SETTLE.
//  MISR: fb = sig[15]^sig[14]^sig[12]^sig[3];
//   sig <= {sig[14:0],fb} ^ zero-extend({stim,resp}).
//  vec_count: +1 per capture, sticks at 16'hFFFF.
//  sig_clr: next edge, signature=SIG_SEED and vec_count=0. It wins over a
//   coincident capture; that capture is still presented on m_data.
//  All arithmetic is unsigned. No combinational path from s_valid or dut_resp
//   to any output; s_ready depends combinationally on m_ready only in RESP.
// TESTING (SETTLE_CYCLES=2, stub DUT: dut_resp = drv_data[2:0])
//  1 Reset held 3 cycles with random inputs -> m_valid=0, s_ready=1,
//    signature=16'hFFFF, vec_count=0, drv_data=0.
//  2 s_data=12'h000 accepted at edge E -> m_valid at E+2, m_data=15'h0000,
//    signature=16'hFFFE, vec_count=1.
//  3 s_data=12'hA5F, m_ready=0 for 5 cycles -> m_data=15'h52FF stable,
//    m_valid=1, s_ready=0 throughout; retires on first m_ready=1.
//  4 Stream 4 vectors with s_valid=1, m_ready=1 -> accept every 3 cycles,
//    no IDLE visits, vec_count=4, signature equals reference-model MISR.
//  5 rst pulsed during SETTLE -> no m_valid, vec_count unchanged at 0,
//    next vector completes normally.
//  6 sig_clr on the capture edge -> m_valid=1 with correct m_data,
//    signature=16'hFFFF, vec_count=0; force count to 16'hFFFF -> stays.

Source files
------------

// File: rtl/stim_resp_driver.sv
// stim_resp_driver
//   Drives one stimulus word at a time onto a combinational datapath under
//   test. It holds the word for a fixed settle time, samples the response and
//   hands {stimulus, response} downstream. Every captured vector is also
//   folded into a MISR signature and counted.
//
//   Handshake rule, used on both the s_* and m_* sides: a word transfers on a
//   rising clk edge where valid and ready are both high. valid, once raised,
//   holds its data stable until that edge.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   s_valid/s_ready/s_data : stimulus input stream
//   drv_data   : stimulus held on the datapath input
//   dut_resp   : datapath output
//   m_valid/m_ready/m_data : result stream {stimulus, response}
//   sig_clr    : clears signature and vec_count on the next edge
//   signature  : running MISR
//   vec_count  : completed vectors, saturating
//   busy       : controller is not idle
module stim_resp_driver #(
   parameter int              IN_W          = 12,
   parameter int              OUT_W         = 3,
   parameter int              SETTLE_CYCLES = 2,
   parameter int              SIG_W         = 16,
   parameter logic [SIG_W-1:0] SIG_SEED     = 16'hFFFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [IN_W-1:0]        s_data,
   output logic [IN_W-1:0]        drv_data,
   input  logic [OUT_W-1:0]       dut_resp,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [IN_W+OUT_W-1:0]  m_data,
   input  logic                   sig_clr,
   output logic [SIG_W-1:0]       signature,
   output logic [15:0]            vec_count,
   output logic                   busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   // Counter only needs to reach SETTLE_CYCLES-1.
   localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam int VEC_W = IN_W + OUT_W;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             capture;
   logic [VEC_W-1:0] vec;
   logic             fb;
   logic [SIG_W-1:0] sig_next;

   // s_ready never looks at s_valid; in RESP it follows m_ready so a retiring
   // result and a new stimulus can share one edge.
   always_comb begin
      s_ready = 1'b0;
      case (state)
         IDLE:    s_ready = 1'b1;
         RESP:    s_ready = m_ready;
         default: s_ready = 1'b0;
      endcase
   end

   assign accept  = s_valid & s_ready;
   assign capture = (state == SETTLE) && (cnt == CNT_LAST);
   assign busy    = (state != IDLE);

   assign vec      = {drv_data, dut_resp};
   assign fb       = signature[SIG_W-1] ^ signature[SIG_W-2] ^ signature[SIG_W-4] ^ signature[3];
   assign sig_next = {signature[SIG_W-2:0], fb} ^ SIG_W'(vec);

   // Controller: drv_data only loads on an accept, so it is frozen in SETTLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         drv_data <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  drv_data <= s_data;
                  cnt      <= '0;
                  state    <= SETTLE;
               end
            end
            SETTLE: begin
               cnt <= cnt + 1'b1;
               if (capture) begin
                  m_data  <= vec;
                  m_valid <= 1'b1;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (s_valid) begin
                     drv_data <= s_data;
                     cnt      <= '0;
                     state    <= SETTLE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

   // Signature and vector count. A clear overrides a capture on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         signature <= SIG_SEED;
         vec_count <= '0;
      end else if (sig_clr) begin
         signature <= SIG_SEED;
         vec_count <= '0;
      end else if (capture) begin
         signature <= sig_next;
         if (vec_count != 16'hFFFF) begin
            vec_count <= vec_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_stim_resp_driver.sv
module tb_stim_resp_driver;

   localparam int IN_W   = 12;
   localparam int OUT_W  = 3;
   localparam int SETTLE = 2;
   localparam int SIG_W  = 16;
   localparam int VEC_W  = IN_W + OUT_W;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              s_valid;
   logic              s_ready;
   logic [IN_W-1:0]   s_data;
   logic [IN_W-1:0]   drv_data;
   logic [OUT_W-1:0]  dut_resp;
   logic              m_valid;
   logic              m_ready;
   logic [VEC_W-1:0]  m_data;
   logic              sig_clr;
   logic [SIG_W-1:0]  signature;
   logic [15:0]       vec_count;
   logic              busy;

   // stub datapath
   assign dut_resp = drv_data[2:0];

   stim_resp_driver #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(SETTLE),
      .SIG_W(SIG_W), .SIG_SEED(16'hFFFF)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .drv_data(drv_data), .dut_resp(dut_resp),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .sig_clr(sig_clr), .signature(signature),
      .vec_count(vec_count), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] model_sig;
   logic [15:0] model_cnt;

   logic [VEC_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // MISR step from the polynomial taps 15,14,12,3 expressed as a parity mask.
   function automatic logic [15:0] misr_ref(input logic [15:0] sig, input logic [VEC_W-1:0] v);
      logic fb;
      fb = ^(sig & 16'hD008);
      return ((sig << 1) | {15'd0, fb}) ^ {1'b0, v};
   endfunction

   function automatic logic [VEC_W-1:0] expect_vec(input logic [IN_W-1:0] d);
      return {d, d[2:0]};
   endfunction

   task automatic model_capture(input logic [VEC_W-1:0] v, input bit clr);
      if (clr) begin
         model_sig = 16'hFFFF;
         model_cnt = 16'd0;
      end else begin
         model_sig = misr_ref(model_sig, v);
         if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      end
   endtask

   task automatic model_reset();
      model_sig = 16'hFFFF;
      model_cnt = 16'd0;
   endtask

   // One isolated vector: accept from IDLE, wait for the result, stall, retire.
   task automatic run_one(input logic [IN_W-1:0] d, input int stall, input bit clr);
      logic [VEC_W-1:0] exp;
      int edges;
      exp = expect_vec(d);
      @(negedge clk);
      check("s_ready_idle", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = d;
      m_ready = 1'b0;
      edges   = 0;
      do begin
         @(negedge clk);
         edges++;
         s_valid = 1'b0;
         s_data  = IN_W'($urandom);
         sig_clr = clr && (edges == SETTLE);
         if (!m_valid) check("drv_hold", 32'(drv_data), 32'(d));
      end while (!m_valid && edges < 12);
      sig_clr = 1'b0;
      check("latency", 32'(edges - 1), 32'(SETTLE));
      check("m_data", 32'(m_data), 32'(exp));
      model_capture(exp, clr);
      check("signature", 32'(signature), 32'(model_sig));
      check("vec_count", 32'(vec_count), 32'(model_cnt));
      check("s_ready_resp_stall", 32'(s_ready), 32'd0);
      repeat (stall) begin
         @(negedge clk);
         check("m_valid_hold", 32'(m_valid), 32'd1);
         check("m_data_hold", 32'(m_data), 32'(exp));
         check("s_ready_hold", 32'(s_ready), 32'd0);
      end
      m_ready = 1'b1;
      #1;
      check("s_ready_follows_m_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      m_ready = 1'b0;
      check("retire_m_valid", 32'(m_valid), 32'd0);
      check("retire_busy", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [IN_W-1:0]  stim;
      logic [VEC_W-1:0] exp_data;
      int               stall;
   } vec_t;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int   sent, got, cyc, last_acc;
      logic [VEC_W-1:0] e;

      tbl[0] = '{12'h000, 15'h0000, 0};
      tbl[1] = '{12'hA5F, 15'h52FF, 5};
      tbl[2] = '{12'hFFF, 15'h7FFF, 1};
      tbl[3] = '{12'h123, 15'h091B, 2};
      tbl[4] = '{12'h800, 15'h4000, 0};
      tbl[5] = '{12'h555, 15'h2AAD, 3};

      s_valid = 0; s_data = 0; m_ready = 0; sig_clr = 0;

      // reset with random inputs
      rst = 1'b1;
      repeat (3) begin
         s_valid = 1'($urandom); s_data = IN_W'($urandom);
         m_ready = 1'($urandom); sig_clr = 1'($urandom);
         @(negedge clk);
      end
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_signature", 32'(signature), 32'hFFFF);
      check("rst_vec_count", 32'(vec_count), 32'd0);
      check("rst_drv_data", 32'(drv_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0; s_valid = 0; m_ready = 0; sig_clr = 0;
      model_reset();

      // table-driven vectors
      for (int i = 0; i < 6; i++) begin
         check("tbl_expect", 32'(expect_vec(tbl[i].stim)), 32'(tbl[i].exp_data));
         run_one(tbl[i].stim, tbl[i].stall, 1'b0);
         if (i == 0) begin
            check("first_sig", 32'(model_sig), 32'hFFFE);
            check("first_cnt", 32'(vec_count), 32'd1);
         end
      end

      // clear, then back-to-back stream of 4 vectors
      @(negedge clk); sig_clr = 1'b1;
      @(negedge clk); sig_clr = 1'b0;
      check("clr_signature", 32'(signature), 32'hFFFF);
      check("clr_vec_count", 32'(vec_count), 32'd0);
      model_reset();
      sent = 0; got = 0; cyc = 0; last_acc = -1;
      s_valid = 1'b1; s_data = IN_W'($urandom); m_ready = 1'b1;
      while (got < 4 && cyc < 60) begin
         bit acc;
         acc = 0;
         if (s_valid && s_ready) begin
            exp_q.push_back(expect_vec(s_data));
            if (last_acc >= 0) check("stream_interval", 32'(cyc - last_acc), 32'(SETTLE + 1));
            last_acc = cyc;
            sent++;
            acc = 1;
         end
         @(negedge clk);
         cyc++;
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               check("stream_unexpected", 32'(m_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("stream_m_data", 32'(m_data), 32'(e));
               model_capture(e, 1'b0);
               check("stream_sig", 32'(signature), 32'(model_sig));
            end
            got++;
         end
         check("stream_busy", 32'(busy), 32'd1);
         if (acc) begin
            s_data  = IN_W'($urandom);
            s_valid = (sent < 4);
         end
      end
      check("stream_got", 32'(got), 32'd4);
      check("stream_count", 32'(vec_count), 32'd4);
      @(negedge clk);
      m_ready = 1'b0;
      check("stream_idle", 32'(busy), 32'd0);

      // reset in the middle of SETTLE
      @(negedge clk);
      s_valid = 1'b1; s_data = 12'h3C7;
      @(negedge clk);
      s_valid = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_vec_count", 32'(vec_count), 32'd0);
      check("midrst_signature", 32'(signature), 32'hFFFF);
      repeat (4) begin
         @(negedge clk);
         check("midrst_no_m_valid", 32'(m_valid), 32'd0);
      end
      run_one(12'h3C7, 0, 1'b0);

      // sig_clr coinciding with the capture edge
      run_one(12'h6B2, 1, 1'b1);
      check("clr_cap_sig", 32'(signature), 32'hFFFF);
      check("clr_cap_cnt", 32'(vec_count), 32'd0);

      // saturation of vec_count
      @(negedge clk);
      force dut.vec_count = 16'hFFFE;
      #1;
      release dut.vec_count;
      model_cnt = 16'hFFFE;
      run_one(12'h0F0, 0, 1'b0);
      check("sat_reach", 32'(vec_count), 32'hFFFF);
      run_one(12'h70F, 0, 1'b0);
      check("sat_stick", 32'(vec_count), 32'hFFFF);

      // randomized vectors against the model
      for (int k = 0; k < 16; k++) begin
         run_one(IN_W'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
